ram2e_bus_tx: RTL

- Apple IIe bus-side initiator that drives the 80-column slot signals seen by the RAM2E card: PHI1, nWE, nC07X, the multiplexed address bus, and the 6502 data bus.
- Generates free-running 1 MHz bus cycles from C14M.
- On request, issues either a single RAMWorks bank-register write or the full 8-write command sequence to $C073.
- Used in the bench/exerciser FPGA as the host-side counterpart of the card.

---
 rtl/ram2e_bus_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram2e_bus_tx.sv
// ram2e_bus_tx: Apple IIe bus-side initiator issuing RAMWorks bank-register writes to $C07X
module ram2e_bus_tx #(
  parameter int PHASE_LEN = 7,
  parameter int GAP_CYCLES = 1,
  parameter logic [7:0] REG_ADDR = 8'h73
) (
  input  logic       C14M,
  input  logic       nRST,
  input  logic       Start,
  input  logic       Seq,
  input  logic [7:0] Cmd,
  input  logic [7:0] Arg,
  output logic       Busy,
  output logic       Done,
  output logic       PHI1,
  output logic       nWE,
  output logic       nC07X,
  output logic [7:0] Aout,
  output logic [7:0] Dout,
  output logic       nDOE
);
  localparam int PW = $clog2(2 * PHASE_LEN);
  localparam logic [PW-1:0] P_LAST = PW'(2 * PHASE_LEN - 1);
  localparam logic [PW-1:0] P_HALF = PW'(PHASE_LEN);
  typedef enum logic [2:0] {IDLE, WAIT, WRITE, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic seq_q, seq_d, wrap, last, wr;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, byte_sel;
  logic [2:0] idx_q, idx_d, gap_q, gap_d;
  logic phi1_q, phi1_d, busy_q, busy_d, done_q, done_d;
  logic nwe_q, nwe_d, nc07x_q, nc07x_d, ndoe_q, ndoe_d;
  logic [7:0] aout_q, aout_d, dout_q, dout_d;
  always_comb begin
    wrap = p_q == P_LAST;
    p_d = wrap ? '0 : p_q + 1'b1;
    last = seq_q ? idx_q == 3'd7 : 1'b1;
    state_d = state_q;
    seq_d = seq_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    idx_d = idx_q;
    gap_d = gap_q;
    case (state_q)
      IDLE: if (Start) begin
        state_d = WAIT;
        seq_d = Seq;
        cmd_d = Cmd;
        arg_d = Arg;
      end
      WAIT: if (wrap) begin
        state_d = WRITE;
        idx_d = '0;
      end
      WRITE: if (wrap) begin
        if (last) state_d = DONE;
        else if (GAP_CYCLES == 0) idx_d = idx_q + 1'b1;
        else begin
          state_d = GAP;
          gap_d = 3'(GAP_CYCLES);
        end
      end
      GAP: if (wrap) begin
        if (gap_q == 3'd1) begin
          state_d = WRITE;
          idx_d = idx_q + 1'b1;
        end else gap_d = gap_q - 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    byte_sel = !seq_q      ? arg_q :
               idx_d == 0  ? 8'hFF :
               idx_d == 1  ? 8'h00 :
               idx_d == 2  ? 8'h55 :
               idx_d == 3  ? 8'hAA :
               idx_d == 4  ? 8'hC1 :
               idx_d == 5  ? 8'hAD :
               idx_d == 6  ? cmd_q : arg_q;
    wr = state_d == WRITE;
    phi1_d = p_d < P_HALF;
    busy_d = state_d inside {WAIT, WRITE, GAP};
    done_d = state_d == DONE;
    nwe_d = !wr;
    nc07x_d = !wr;
    ndoe_d = !wr;
    aout_d = wr ? REG_ADDR : 8'h00;
    dout_d = wr ? byte_sel : dout_q;
  end
  always_ff @(posedge C14M or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      p_q <= '0;
      seq_q <= 1'b0;
      cmd_q <= '0;
      arg_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
      phi1_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nwe_q <= 1'b1;
      nc07x_q <= 1'b1;
      ndoe_q <= 1'b1;
      aout_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      seq_q <= seq_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      phi1_q <= phi1_d;
      busy_q <= busy_d;
      done_q <= done_d;
      nwe_q <= nwe_d;
      nc07x_q <= nc07x_d;
      ndoe_q <= ndoe_d;
      aout_q <= aout_d;
      dout_q <= dout_d;
    end
  end
  assign PHI1 = phi1_q;
  assign Busy = busy_q;
  assign Done = done_q;
  assign nWE = nwe_q;
  assign nC07X = nc07x_q;
  assign nDOE = ndoe_q;
  assign Aout = aout_q;
  assign Dout = dout_q;
endmodule
